// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache with LRU replacement.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       word0_q, word0_d;
  logic [1:0]        valid_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [63:0]       data_q  [SETS][2];

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              wsel_s;
  logic [1:0]        hit_vec_s;
  logic              hit_s;
  logic              hit_way_s;
  logic              fill_way_s;
  logic [63:0]       hit_line_s;
  logic [31:0]       hit_word_s;
  logic              line_we_s;
  logic              word_we_s;
  logic              lru_we_s;
  logic              lru_val_s;
  logic              addr_unused_s;

  assign idx_s         = address[IDX_W+2:3];
  assign tag_s         = address[9+TAG_W-1:9];
  assign wsel_s        = address[2];
  assign addr_unused_s = ^address[1:0];

  // Tag lookup for the live request; way 0 wins if both ways ever match.
  always_comb begin
    hit_vec_s[0] = valid_q[idx_s][0] && (tag_q[idx_s][0] == tag_s);
    hit_vec_s[1] = valid_q[idx_s][1] && (tag_q[idx_s][1] == tag_s);
    hit_s        = |hit_vec_s;
    hit_way_s    = ~hit_vec_s[0];
    fill_way_s   = lru_q[idx_s];
    hit_line_s   = data_q[idx_s][hit_way_s];
    hit_word_s   = wsel_s ? hit_line_s[63:32] : hit_line_s[31:0];
  end

  always_comb begin
    state_d      = state_q;
    word0_d      = word0_q;
    ready        = 1'b1;
    rdata        = 32'd0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = 32'd0;
    sram_wdata   = 32'd0;
    line_we_s    = 1'b0;
    word_we_s    = 1'b0;
    lru_we_s     = 1'b0;
    lru_val_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          ready   = 1'b0;
          state_d = WRITE;
        end else if (rd_en) begin
          if (hit_s) begin
            rdata     = hit_word_s;
            lru_we_s  = 1'b1;
            lru_val_s = ~hit_way_s;
          end else begin
            ready   = 1'b0;
            state_d = FILL0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL0: begin
        ready        = 1'b0;
        sram_rd_en   = 1'b1;
        sram_address = {address[31:3], 3'b000};
        if (sram_ready) begin
          word0_d = sram_rdata;
          state_d = FILL1;
        end else begin
          state_d = FILL0;
        end
      end
      FILL1: begin
        ready        = 1'b0;
        sram_rd_en   = 1'b1;
        sram_address = {address[31:3], 3'b100};
        if (sram_ready) begin
          line_we_s = 1'b1;
          lru_we_s  = 1'b1;
          lru_val_s = ~fill_way_s;
          state_d   = IDLE;
        end else begin
          state_d = FILL1;
        end
      end
      WRITE: begin
        sram_wr_en   = 1'b1;
        sram_address = {address[31:2], 2'b00};
        sram_wdata   = wdata;
        ready        = sram_ready;
        if (sram_ready) begin
          state_d = IDLE;
          if (hit_s) begin
            word_we_s = 1'b1;
            lru_we_s  = 1'b1;
            lru_val_s = ~hit_way_s;
          end else begin
            word_we_s = 1'b0;
          end
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      word0_q <= 32'd0;
      lru_q   <= {SETS{1'b0}};
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 2'b00;
      end
    end else begin
      state_q <= state_d;
      word0_q <= word0_d;
      if (line_we_s) begin
        valid_q[idx_s][fill_way_s] <= 1'b1;
      end
      if (lru_we_s) begin
        lru_q[idx_s] <= lru_val_s;
      end
    end
  end

  // Tag and data arrays need no reset: the valid bits guard every use.
  always_ff @(posedge clk) begin
    if (rst && line_we_s) begin
      tag_q[idx_s][fill_way_s]  <= tag_s;
      data_q[idx_s][fill_way_s] <= {sram_rdata, word0_q};
    end else if (rst && word_we_s) begin
      if (wsel_s) begin
        data_q[idx_s][hit_way_s][63:32] <= wdata;
      end else begin
        data_q[idx_s][hit_way_s][31:0] <= wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        fill_done_q, fill_done_d;
  logic        rd_hit_s;
  logic        rd_miss_s;

  // The hit that retires a just-filled miss is not a new hit.
  always_comb begin
    rd_hit_s     = (state_q == IDLE) && rd_en && !wr_en && hit_s && !fill_done_q;
    rd_miss_s    = (state_q == IDLE) && rd_en && !wr_en && !hit_s;
    fill_done_d  = line_we_s;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rd_hit_s && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if (rd_miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
      fill_done_q  <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      fill_done_q  <= fill_done_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a timestamp-LRU reference model predicts each
// transaction's data and hit/miss, and a monitor checks them when the DUT raises ready.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller #(.SETS(64), .TAG_W(10)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        miss;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] sram_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];
  int unsigned line_stamp [int unsigned];
  int unsigned stamp_ctr = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  logic        rand_lat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] sram_read(input logic [31:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Cache as a set of resident lines keyed by {tag,index}; victim = oldest stamp in its set.
  function automatic logic model_access(input logic [31:0] a, input logic allocate);
    int unsigned key;
    int unsigned old_key;
    int unsigned old_stamp;
    int          n;
    key = {16'd0, a[18:3]};
    if (line_stamp.exists(key)) begin
      stamp_ctr++;
      line_stamp[key] = stamp_ctr;
      return 1'b1;
    end
    if (allocate) begin
      n = 0;
      old_key = 0;
      old_stamp = 32'hFFFF_FFFF;
      foreach (line_stamp[k]) begin
        if (k[5:0] == a[8:3]) begin
          n++;
          if (line_stamp[k] < old_stamp) begin
            old_stamp = line_stamp[k];
            old_key = k;
          end
        end
      end
      if (n >= 2) line_stamp.delete(old_key);
      stamp_ctr++;
      line_stamp[key] = stamp_ctr;
    end
    return 1'b0;
  endfunction

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL %s timeout actual=ready_low required=ready_high", name);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    exp_t e;
    logic h;
    h = model_access(a, 1'b1);
    if (h) exp_hits++; else exp_misses++;
    e.is_wr = 1'b0; e.addr = a; e.data = ref_read(a); e.miss = ~h;
    exp_q.push_back(e);
    rd_en = 1'b1; wr_en = 1'b0; address = a; wdata = $urandom;
    wait_done("read");
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
    exp_t e;
    logic h;
    h = model_access(a, 1'b0);
    ref_mem[a] = d;
    e.is_wr = 1'b1; e.addr = a; e.data = d; e.miss = ~h;
    exp_q.push_back(e);
    rd_en = both; wr_en = 1'b1; address = a; wdata = d;
    wait_done("write");
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [9:0] tg;
    logic [5:0] ix;
    logic       w;
    tg = 10'($urandom_range(0, 3));
    ix = 6'($urandom_range(0, 3));
    w  = 1'($urandom_range(0, 1));
    return {13'd0, tg, ix, w, 2'b00};
  endfunction

  // SRAM responder: one-cycle sram_ready pulse after a (possibly random) latency.
  initial begin
    int lat;
    int wcnt;
    lat = 3;
    wcnt = 0;
    sram_ready = 1'b0;
    sram_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        sram_ready = 1'b0;
        wcnt = 0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        wcnt = 0;
      end else if (sram_rd_en || sram_wr_en) begin
        wcnt++;
        if (wcnt >= lat) begin
          sram_ready = 1'b1;
          if (sram_wr_en) begin
            sram_mem[sram_address] = sram_wdata;
            last_wr_addr = sram_address;
            last_wr_data = sram_wdata;
          end else begin
            sram_rdata = sram_read(sram_address);
          end
          wcnt = 0;
          lat = rand_lat ? $urandom_range(1, 4) : 3;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a request completes.
  initial begin
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] rd_addr [2];
    exp_t        e;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_addr[0] = 32'd0;
    rd_addr[1] = 32'd0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (sram_ready && sram_rd_en) begin
          if (rd_cnt < 2) rd_addr[rd_cnt] = sram_address;
          rd_cnt++;
        end
        if (sram_ready && sram_wr_en) wr_cnt++;
        if (!rd_en && !wr_en) begin
          chk("idle_ready", {31'd0, ready}, 32'd1);
          chk("idle_rdata", rdata, 32'd0);
        end else if (!ready) begin
          if (rd_en && !wr_en) chk("stall_rdata", rdata, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_wr) begin
            chk("wr_rdata", rdata, 32'd0);
            chk("wr_sram_writes", 32'(wr_cnt), 32'd1);
            chk("wr_sram_reads", 32'(rd_cnt), 32'd0);
            chk("wr_sram_addr", last_wr_addr, {e.addr[31:2], 2'b00});
            chk("wr_sram_data", last_wr_data, e.data);
          end else begin
            chk("rd_data", rdata, e.data);
            chk("rd_fill_reads", 32'(rd_cnt), e.miss ? 32'd2 : 32'd0);
            chk("rd_sram_writes", 32'(wr_cnt), 32'd0);
            chk("rd_done_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
            if (e.miss) begin
              chk("fill_addr0", rd_addr[0], {e.addr[31:3], 3'b000});
              chk("fill_addr1", rd_addr[1], {e.addr[31:3], 3'b100});
            end
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; wdata = 32'd0;
    sram_mem[32'h400] = 32'hAAAA_0000; ref_mem[32'h400] = 32'hAAAA_0000;
    sram_mem[32'h404] = 32'h1111_2222; ref_mem[32'h404] = 32'h1111_2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("reset_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_read(32'h0000_0404);
`ifdef CACHE_STATS_EN
    chk("miss_count_cold", miss_count, 32'd1);
`endif
    do_read(32'h0000_0400);
`ifdef CACHE_STATS_EN
    chk("hit_count_repeat", hit_count, 32'd1);
`endif
    do_read(32'h200); do_read(32'h400); do_read(32'h200);
    do_read(32'h600); do_read(32'h200); do_read(32'h400);
    do_write(32'h404, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h404);
    do_write(32'h808, 32'h1234_5678, 1'b0);
    do_read(32'h808);
    do_write(32'h10, 32'h0BAD_F00D, 1'b1);
    do_read(32'h10);

    rand_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      if (n < 6) do_read(rand_addr());
      else if (n < 9) do_write(rand_addr(), $urandom, 1'b0);
      else do_write(rand_addr(), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef CACHE_STATS_EN
    chk("hit_count_total", hit_count, 32'(exp_hits));
    chk("miss_count_total", miss_count, 32'(exp_misses));
`endif

    // Abort a fill with reset while in its second SRAM read.
    rand_lat = 1'b0;
    rd_en = 1'b1; address = 32'h0000_0BF8;
    n = 0;
    forever begin
      @(negedge clk);
      if (sram_ready && sram_rd_en) break;
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL abort_fill timeout actual=no_sram_ready required=sram_ready");
        finish_run();
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("abort_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    line_stamp.delete();
    exp_hits = 0;
    exp_misses = 0;
    do_read(32'h0000_0BF8);
    do_read(32'h0000_0400);
`ifdef CACHE_STATS_EN
    chk("miss_count_after_reset", miss_count, 32'(exp_misses));
`endif
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule
